gpio_in_debounce: RTL and testbench

Input-conditioning stage for the Marsohod board tops. It takes raw board pins (KEY0, IO header inputs) and produces clean, synchronized, debounced levels that drive the SoC's `gpio0_i` bus. It also produces one-cycle edge pulses and, optionally, sticky per-bit event flags with a combined interrupt line. It runs in the `wb_clk` domain, between the pads and `picorv32_wb_soc`.

---
 rtl/gpio_in_debounce.sv | 74 +++++++
 tb/tb_gpio_in_debounce.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// Pad input conditioner: per-bit synchronizer, debounce counter, edge pulses.
// Optional sticky event flags and irq_o when GPIO_IN_EVENT_EN is defined.
module gpio_in_debounce #(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 24000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  input  logic [WIDTH-1:0] evt_clr_i,
  output logic [WIDTH-1:0] evt_o,
  output logic             irq_o
);

  localparam int unsigned    CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0]                  stb;
  logic [CW-1:0]                     cnt [WIDTH];

  assign sync   = chain[SYNC_STAGES-1];
  assign gpio_o = stb;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      chain  <= {SYNC_STAGES{RESET_LEVEL}};
      stb    <= RESET_LEVEL;
      rise_o <= '0;
      fall_o <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pad_i};
      for (int unsigned i = 0; i < WIDTH; i++) begin
        rise_o[i] <= 1'b0;
        fall_o[i] <= 1'b0;
        // Any sample matching the stable level discards the partial count.
        if (sync[i] == stb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stb[i]    <= sync[i];
          cnt[i]    <= '0;
          rise_o[i] <= sync[i];
          fall_o[i] <= ~sync[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef GPIO_IN_EVENT_EN
  // Set from the registered pulses; set wins over a same-edge clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) evt_o <= '0;
    else             evt_o <= (evt_o & ~evt_clr_i) | rise_o | fall_o;
  end

  assign irq_o = |evt_o;
`else
  logic unused_clr;

  assign unused_clr = ^evt_clr_i;
  assign evt_o      = '0;
  assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Event expectations follow GPIO_IN_EVENT_EN when the bench is built with it.
module tb_gpio_in_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pad = 8'h00;
  logic [7:0] clr = 8'h00;
  logic [7:0] gpio, rise, fall, evt;
  logic       irq;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [7:0] pad;
    logic [7:0] clr;
    logic [7:0] gpio;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] evt;
  } vec_t;

  vec_t tbl[$];

  gpio_in_debounce #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .pad_i     (pad),
    .gpio_o    (gpio),
    .rise_o    (rise),
    .fall_o    (fall),
    .evt_clr_i (clr),
    .evt_o     (evt),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ev(input logic [7:0] e);
`ifdef GPIO_IN_EVENT_EN
    return e;
`else
    return 8'h00 & e;
`endif
  endfunction

  task automatic add(input int n, input logic [7:0] p, input logic [7:0] c,
                     input logic [7:0] g, input logic [7:0] r, input logic [7:0] f,
                     input logic [7:0] e);
    vec_t v;
    v.pad = p; v.clr = c; v.gpio = g; v.rise = r; v.fall = f; v.evt = e;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic check_all(input string tag, input logic [7:0] g, input logic [7:0] r,
                           input logic [7:0] f, input logic [7:0] e);
    chk({tag, ".gpio"}, gpio, g);
    chk({tag, ".rise"}, rise, r);
    chk({tag, ".fall"}, fall, f);
    chk({tag, ".evt"},  evt,  ev(e));
    chk({tag, ".irq"},  {7'd0, irq}, {7'd0, |ev(e)});
  endtask

  task automatic do_reset(input logic [7:0] p);
    rst_n = 1'b0;
    pad   = p;
    clr   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // pad, clr, gpio, rise, fall, evt
    add(5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);  // reset exit latency
    add(1, 8'h5A, 8'h00, 8'h5A, 8'h5A, 8'h00, 8'h00);
    add(1, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h5A);
    add(1, 8'h5A, 8'hFF, 8'h5A, 8'h00, 8'h00, 8'h00);
    add(3, 8'h5B, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00);  // 3-cycle glitch rejected
    add(5, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00);
    add(4, 8'h5B, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00);  // 4-cycle pulse accepted
    add(1, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00);
    add(1, 8'h5A, 8'h00, 8'h5B, 8'h01, 8'h00, 8'h00);
    add(3, 8'h5A, 8'h00, 8'h5B, 8'h00, 8'h00, 8'h01);
    add(1, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h01, 8'h01);
    add(1, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h01);
    add(1, 8'h5A, 8'hFF, 8'h5A, 8'h00, 8'h00, 8'h00);
    add(5, 8'hDA, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00);  // bit 7 rise
    add(1, 8'hDA, 8'h00, 8'hDA, 8'h80, 8'h00, 8'h00);
    add(1, 8'hDA, 8'h00, 8'hDA, 8'h00, 8'h00, 8'h80);
    add(1, 8'hDA, 8'h80, 8'hDA, 8'h00, 8'h00, 8'h00);
    add(5, 8'h5A, 8'h00, 8'hDA, 8'h00, 8'h00, 8'h00);  // bit 7 fall
    add(1, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h80, 8'h00);
    add(1, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h80);
    add(5, 8'hDA, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h80);  // rise while flag set
    add(1, 8'hDA, 8'h00, 8'hDA, 8'h80, 8'h00, 8'h80);
    add(1, 8'hDA, 8'h80, 8'hDA, 8'h00, 8'h00, 8'h80);  // set beats clear
    add(1, 8'hDA, 8'h80, 8'hDA, 8'h00, 8'h00, 8'h00);  // clear alone

    do_reset(8'h5A);
    foreach (tbl[i]) begin
      pad = tbl[i].pad;
      clr = tbl[i].clr;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i + 1), tbl[i].gpio, tbl[i].rise, tbl[i].fall, tbl[i].evt);
    end

    // Bounce on bit 3: 1,0,1,0 then hold 1; final 0->1 is at step 4.
    do_reset(8'h00);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    begin
      int rises = 0;
      for (int j = 0; j < 13; j++) begin
        pad = (j >= 4 || (j % 2) == 0) ? 8'h08 : 8'h00;
        @(posedge clk);
        #1;
        if (rise[3]) rises++;
        chk($sformatf("bounce%0d.gpio", j), gpio, (j >= 9) ? 8'h08 : 8'h00);
        chk($sformatf("bounce%0d.rise", j), rise, (j == 9) ? 8'h08 : 8'h00);
      end
      chk("bounce.rise_count", 8'(rises), 8'd1);
    end

    // Reset asserted three edges into a count, then normal debounce after release.
    do_reset(8'h00);
    pad = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("midreset", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("release%0d", j), (j >= 6) ? 8'hFF : 8'h00,
                (j == 6) ? 8'hFF : 8'h00, 8'h00, (j == 7) ? 8'hFF : 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
